// File: rtl/button_event_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder_pkg
// Brief    : State encodings and shared widths for the button event decoder.
// Revision : 1.0 - initial release
// ============================================================================
package button_event_decoder_pkg;

  localparam int COUNT_W = 8;

  // Encoding 3 is unused and is recovered to IDLE by the decoder.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } btn_state_t;

endpackage : button_event_decoder_pkg
`default_nettype wire

// File: rtl/button_event_decoder_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : edge_detector
// Brief    : Rise/fall detector on a clk-synchronous level.
// Revision : 1.0 - initial release
// ============================================================================
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise,
  output logic fall
);

  logic r_prev;

  // prev follows the input even during reset, so a level held through reset
  // produces no edge once reset is released.
  always_ff @(posedge clk) begin
    r_prev <= in;
  end

  assign rise = ~rst &  in & ~r_prev;
  assign fall = ~rst & ~in &  r_prev;

endmodule : edge_detector
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder
// Brief    : Turns a debounced button level into press/release/long/repeat
//            single-cycle events plus a wrapping press counter.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         button_state,
  output logic         press_pulse,
  output logic         release_pulse,
  output logic         long_pulse,
  output logic         repeat_pulse,
  output logic         held,
  output logic [7:0]   press_count
);

  localparam logic [CNT_W-1:0] c_long_last   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_repeat_last = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
  localparam logic [COUNT_W-1:0] c_count_one = COUNT_W'(1);

  btn_state_t         r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [COUNT_W-1:0] r_press_count, w_press_count_n;
  logic               r_press, r_release, r_long, r_repeat, r_held;
  logic               w_press_n, w_release_n, w_long_n, w_repeat_n, w_held_n;
  logic               w_rise;
  logic               w_fall;

  edge_detector u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (button_state),
    .rise (w_rise),
    .fall (w_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_press_count <= '0;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_long        <= 1'b0;
      r_repeat      <= 1'b0;
      r_held        <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_cnt         <= w_cnt_n;
      r_press_count <= w_press_count_n;
      r_press       <= w_press_n;
      r_release     <= w_release_n;
      r_long        <= w_long_n;
      r_repeat      <= w_repeat_n;
      r_held        <= w_held_n;
    end
  end

  // Release is tested before the threshold so it wins on the same edge.
  always_comb begin
    w_state_n       = r_state;
    w_cnt_n         = r_cnt;
    w_press_count_n = r_press_count;
    w_press_n       = 1'b0;
    w_release_n     = 1'b0;
    w_long_n        = 1'b0;
    w_repeat_n      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_n       = ST_PRESS;
          w_cnt_n         = '0;
          w_press_n       = 1'b1;
          w_press_count_n = r_press_count + c_count_one;
        end
      end
      ST_PRESS: begin
        if (!button_state) begin
          w_state_n   = ST_IDLE;
          w_release_n = 1'b1;
        end else if (r_cnt == c_long_last) begin
          w_state_n = ST_HOLD;
          w_long_n  = 1'b1;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + c_cnt_one;
        end
      end
      ST_HOLD: begin
        if (!button_state) begin
          w_state_n   = ST_IDLE;
          w_release_n = 1'b1;
        end else if (r_cnt == c_repeat_last) begin
          w_repeat_n = 1'b1;
          w_cnt_n    = '0;
        end else begin
          w_cnt_n = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
    endcase
    w_held_n = (w_state_n == ST_HOLD);
  end

  // w_fall is not needed by the FSM: release is decided from the level so a
  // fall seen in IDLE (button held through reset) is ignored naturally.
  logic w_unused;
  assign w_unused = w_fall;

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
  assign repeat_pulse  = r_repeat;
  assign held          = r_held;
  assign press_count   = r_press_count;

endmodule : button_event_decoder
`default_nettype wire
